// File: rtl/adc_scan_display.sv
// adc_scan_display: scans NUM_CH XADC aux channels over DRP, box-car averages,
// shows the selected channel on LEDs and as millivolts on an 8-digit display.
// Ports:
//   CLK100MHZ/CPU_RESETN : clock and async active-low reset
//   sel                  : channel to display
//   drp_*                : XADC DRP read port (daddr/den out, do/drdy in)
//   LED                  : [15:4] averaged code, [3] timeout sticky
//   an/seg/dp            : multiplexed 7-segment display, active low
`timescale 1ns/1ps
module adc_scan_display #(
  parameter int         NUM_CH      = 4,
  parameter logic [6:0] BASE_ADDR   = 7'h13,
  parameter int         AVG_LOG2    = 4,
  parameter int         SAMPLE_DIV  = 10000,
  parameter int         REFRESH_DIV = 100000,
  parameter int         DRP_TIMEOUT = 255
) (
  input  logic        CLK100MHZ,
  input  logic        CPU_RESETN,
  input  logic [2:0]  sel,
  output logic [6:0]  drp_daddr,
  output logic        drp_den,
  input  logic [15:0] drp_do,
  input  logic        drp_drdy,
  output logic [15:0] LED,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int AW    = 12 + AVG_LOG2;
  localparam int CW    = AVG_LOG2 + 1;
  localparam int NSAMP = 1 << AVG_LOG2;
  localparam int SDW   = (SAMPLE_DIV > 1) ?
                         $clog2(SAMPLE_DIV) : 1;
  localparam int RDW   = (REFRESH_DIV > 1) ?
                         $clog2(REFRESH_DIV) : 1;
  localparam int TW    = $clog2(DRP_TIMEOUT + 1);
  localparam logic [6:0] DASH = 7'h3F;

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, NEXT
  } state_e;

  logic           clk, rst_n;
  assign clk   = CLK100MHZ;
  assign rst_n = CPU_RESETN;

  state_e         state_q, state_d;
  logic [SDW-1:0] div_q, div_d;
  logic           tick;
  logic [2:0]     ch_q, ch_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [TW-1:0]  tmo_q, tmo_d;
  logic           tmo_hit;
  logic           sticky_q, sticky_d;
  logic           upd_q, upd_d;
  logic [AW-1:0]  acc_q [NUM_CH];
  logic [AW-1:0]  acc_d [NUM_CH];
  logic [11:0]    avg_q [NUM_CH];
  logic [11:0]    avg_d [NUM_CH];

  // sample tick
  always_comb begin
    tick  = (div_q == SDW'(SAMPLE_DIV - 1));
    div_d = tick ? '0 : div_q + 1'b1;
  end

  assign tmo_hit = (tmo_q == TW'(DRP_TIMEOUT - 1));

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (tick) state_d = REQ;
      REQ:  state_d = WAIT;
      WAIT: if (drp_drdy || tmo_hit)
              state_d = NEXT;
      NEXT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    drp_den   = (state_q == REQ);
    drp_daddr = BASE_ADDR + {4'b0, ch_q};
  end

  // scan datapath
  always_comb begin
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    sticky_d = sticky_q;
    upd_d    = 1'b0;
    acc_d    = acc_q;
    avg_d    = avg_q;
    unique case (state_q)
      REQ: tmo_d = '0;
      WAIT: begin
        tmo_d = tmo_q + 1'b1;
        if (drp_drdy) begin
          for (int n = 0; n < NUM_CH; n++)
            if (ch_q == 3'(n))
              acc_d[n] = acc_q[n] +
                         AW'(drp_do[15:4]);
        end else if (tmo_hit) begin
          sticky_d = 1'b1;
        end
      end
      NEXT: begin
        if (ch_q == 3'(NUM_CH - 1)) begin
          ch_d = '0;
          if (cnt_q == CW'(NSAMP - 1)) begin
            for (int n = 0; n < NUM_CH; n++) begin
              avg_d[n] = acc_q[n][AVG_LOG2 +: 12];
              acc_d[n] = '0;
            end
            cnt_d = '0;
            upd_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= '0;
      ch_q     <= '0;
      cnt_q    <= '0;
      tmo_q    <= '0;
      sticky_q <= 1'b0;
      upd_q    <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) begin
        acc_q[n] <= '0;
        avg_q[n] <= '0;
      end
    end else begin
      div_q    <= div_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      sticky_q <= sticky_d;
      upd_q    <= upd_d;
      acc_q    <= acc_d;
      avg_q    <= avg_d;
    end
  end

  // selected channel, LEDs and millivolts
  logic [11:0] sel_avg;
  logic        sel_ok;
  logic [21:0] prod;
  logic [9:0]  mv;
  logic [11:0] led_q;

  always_comb begin
    sel_avg = '0;
    sel_ok  = 1'b0;
    for (int n = 0; n < NUM_CH; n++)
      if (sel == 3'(n)) begin
        sel_avg = avg_q[n];
        sel_ok  = 1'b1;
      end
    prod = 22'(sel_avg) * 22'd1000;
    mv   = prod[21:12];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= sel_avg;
  end

  assign LED = {led_q, sticky_q, 3'b000};

  // double-dabble; digits commit only when done
  logic [2:0]  sel_prev_q;
  logic        start;
  logic        busy_q;
  logic [3:0]  bits_q;
  logic [9:0]  bin_q;
  logic [11:0] bcd_q, bcd_adj, bcd_nx;
  logic [2:0]  psel_q, dsel_q;
  logic        pok_q, dok_q;
  logic [11:0] dig_q;

  assign start = upd_q || (sel != sel_prev_q);

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4];
      if (bcd_q[i*4 +: 4] >= 4'd5)
        bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
    bcd_nx = {bcd_adj[10:0], bin_q[9]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_prev_q <= '0;
      busy_q     <= 1'b0;
      bits_q     <= '0;
      bin_q      <= '0;
      bcd_q      <= '0;
      psel_q     <= '0;
      pok_q      <= 1'b0;
      dsel_q     <= '0;
      dok_q      <= 1'b0;
      dig_q      <= '0;
    end else begin
      sel_prev_q <= sel;
      if (start) begin
        busy_q <= 1'b1;
        bits_q <= 4'd10;
        bin_q  <= mv;
        bcd_q  <= '0;
        psel_q <= sel;
        pok_q  <= sel_ok;
      end else if (busy_q) begin
        bcd_q  <= bcd_nx;
        bin_q  <= {bin_q[8:0], 1'b0};
        bits_q <= bits_q - 1'b1;
        if (bits_q == 4'd1) begin
          busy_q <= 1'b0;
          dig_q  <= bcd_nx;
          dsel_q <= psel_q;
          dok_q  <= pok_q;
        end
      end
    end
  end

  // digit scan
  function automatic logic [6:0] hex7(
    input logic [3:0] d
  );
    case (d)
      4'h0: hex7 = 7'h40;
      4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;
      4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;
      4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;
      4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;
      4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;
      4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;
      4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;
      default: hex7 = 7'h0E;
    endcase
  endfunction

  logic [RDW-1:0] ref_q;
  logic           ref_tc;
  logic [2:0]     idx_q;
  logic [7:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;

  assign ref_tc = (ref_q == RDW'(REFRESH_DIV - 1));

  always_comb begin
    an_d  = ~(8'b1 << idx_q);
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    unique case (1'b1)
      (idx_q == 3'd3): begin
        seg_d = dok_q ? hex7({1'b0, dsel_q}) : DASH;
        dp_d  = ~dok_q;
      end
      (idx_q == 3'd2):
        seg_d = dok_q ? hex7(dig_q[11:8]) : DASH;
      (idx_q == 3'd1):
        seg_d = dok_q ? hex7(dig_q[7:4]) : DASH;
      (idx_q == 3'd0):
        seg_d = dok_q ? hex7(dig_q[3:0]) : DASH;
      default: ;
    endcase
  end

  // an/seg/dp share one register stage so they switch together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ref_q <= '0;
      idx_q <= '0;
      an_q  <= 8'hFF;
      seg_q <= 7'h7F;
      dp_q  <= 1'b1;
    end else begin
      ref_q <= ref_tc ? '0 : ref_q + 1'b1;
      if (ref_tc) idx_q <= idx_q + 1'b1;
      an_q  <= an_d;
      seg_q <= seg_d;
      dp_q  <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

  logic unused_bits;
  assign unused_bits = ^{drp_do[3:0], prod[11:0]};

endmodule
